// File: rtl/lcd_frame_monitor.sv
// ---------------------------------------------------------------------------
// lcd_frame_monitor
// Follows a parallel RGB LCD stream clocked by DCLK. HSD and VSD are
// active-low. The block rebuilds the x/line position from the sync falling
// edges and tracks timing lock. It outputs window-relative pixel coordinates
// with a valid flag, frame start/done pulses, a count of completed frames,
// and 1-cycle line/frame length error pulses. All outputs are registered.
//
// Ports:
//   i_clk, i_rstn        pixel clock; synchronous active-low reset
//   i_hsd, i_vsd         horizontal / vertical sync, active-low
//   i_r, i_g, i_b        pixel colour, COLOR_W bits each
//   o_pix_vld            active-window pixel valid (1-cycle latency)
//   o_pix_x, o_pix_y     position inside the active window
//   o_pix_rgb            {R,G,B} of the valid pixel
//   o_frame_start/done   coincide with pixel (0,0) / (H_ACT-1,V_ACT-1)
//   o_frame_cnt          completed frames, wraps at 2^FCNT_W
//   o_locked             timing lock status
//   o_h_err, o_v_err     line / frame length mismatch pulses
//   o_frame_crc          only when LCD_FRAME_MONITOR_CRC_EN is defined:
//                        CRC-32 (MSB-first) of the last completed frame
//
// Optional feature macro: LCD_FRAME_MONITOR_CRC_EN
// ---------------------------------------------------------------------------
module lcd_frame_monitor #(
  parameter int H_TOTAL     = 1056,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 50,
  parameter int H_ACT       = 800,
  parameter int V_ACT_START = 23,
  parameter int V_ACT       = 480,
  parameter int COLOR_W     = 8,
  parameter int FCNT_W      = 16,
  parameter int LOCK_FRAMES = 2,
  localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1,
  localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_hsd,
  input  logic                 i_vsd,
  input  logic [COLOR_W-1:0]   i_r,
  input  logic [COLOR_W-1:0]   i_g,
  input  logic [COLOR_W-1:0]   i_b,
  output logic                 o_pix_vld,
  output logic [XW-1:0]        o_pix_x,
  output logic [YW-1:0]        o_pix_y,
  output logic [3*COLOR_W-1:0] o_pix_rgb,
  output logic                 o_frame_start,
  output logic                 o_frame_done,
  output logic [FCNT_W-1:0]    o_frame_cnt,
  output logic                 o_locked,
  output logic                 o_h_err,
`ifdef LCD_FRAME_MONITOR_CRC_EN
  output logic                 o_v_err,
  output logic [31:0]          o_frame_crc
`else
  output logic                 o_v_err
`endif
);

  // Counter widths hold values up to the full totals, so the window end fits.
  localparam int XCW = $clog2(H_TOTAL + 1);
  localparam int LCW = $clog2(V_TOTAL + 1);

  localparam logic [XCW-1:0] H_LAST = XCW'(H_TOTAL - 1);
  localparam logic [XCW-1:0] X_LO   = XCW'(H_ACT_START);
  localparam logic [XCW-1:0] X_HI   = XCW'(H_ACT_START + H_ACT);
  localparam logic [XCW-1:0] X_END  = XCW'(H_ACT_START + H_ACT - 1);
  localparam logic [LCW-1:0] L_LAST = LCW'(V_TOTAL - 1);
  localparam logic [LCW-1:0] Y_LO   = LCW'(V_ACT_START);
  localparam logic [LCW-1:0] Y_HI   = LCW'(V_ACT_START + V_ACT);
  localparam logic [LCW-1:0] Y_END  = LCW'(V_ACT_START + V_ACT - 1);

  typedef enum logic [1:0] {ST_UNLOCKED = 2'd0, ST_ALIGN = 2'd1, ST_LOCKED = 2'd2} state_e;

  function automatic logic [LCW-1:0] line_inc(input logic [LCW-1:0] l);
    if (l == L_LAST) return '0;
    else             return l + LCW'(1);
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           clean_q, clean_d;
  logic                 frame_err_q, frame_err_d;
  logic                 s_hsd_q, s_vsd_q;
  logic [XCW-1:0]       x_cnt_q, x_cnt_d;
  logic [LCW-1:0]       line_cnt_q, line_cnt_d;
  logic                 pix_vld_q, pix_vld_d;
  logic [XW-1:0]        pix_x_q, pix_x_d;
  logic [YW-1:0]        pix_y_q, pix_y_d;
  logic [3*COLOR_W-1:0] pix_rgb_q, pix_rgb_d;
  logic                 fstart_q, fstart_d, fdone_q, fdone_d;
  logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
  logic                 locked_q, locked_d;
  logic                 h_err_q, v_err_q;

  logic                 h_fall_s, v_fall_s, chk_s, h_err_s, v_err_s, err_s, x_wrap_s;
  logic [XCW-1:0]       x_eff_s;
  logic [LCW-1:0]       line_h_s, y_eff_s;

  // Position tracking, error detection, lock FSM next-state and pixel output.
  always_comb begin
    h_fall_s = ~i_hsd & s_hsd_q;
    v_fall_s = ~i_vsd & s_vsd_q;
    x_eff_s  = h_fall_s ? '0 : x_cnt_q;
    // An h_fall right after a natural wrap (x_cnt==0) must not add a second line.
    line_h_s = (h_fall_s && (x_cnt_q != '0)) ? line_inc(line_cnt_q) : line_cnt_q;
    y_eff_s  = v_fall_s ? '0 : line_h_s;
    x_wrap_s = (x_eff_s == H_LAST);
    x_cnt_d    = x_wrap_s ? '0 : x_eff_s + XCW'(1);
    line_cnt_d = x_wrap_s ? line_inc(y_eff_s) : y_eff_s;

    chk_s   = (state_q != ST_UNLOCKED);
    h_err_s = chk_s & h_fall_s & (x_cnt_q != '0);
    v_err_s = chk_s & v_fall_s & (line_h_s != '0);
    err_s   = h_err_s | v_err_s;

    // Sticky per-frame error; the frame boundary at v_fall starts a new window.
    frame_err_d = v_fall_s ? 1'b0 : (frame_err_q | err_s);
    state_d     = state_q;
    clean_d     = clean_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (v_fall_s) begin
          state_d = ST_ALIGN;
          clean_d = 4'd0;
        end else begin
          clean_d = 4'd0;
        end
      end
      ST_ALIGN: begin
        if (err_s || (v_fall_s && frame_err_q)) begin
          clean_d = 4'd0;
        end else if (v_fall_s) begin
          if ((clean_q + 4'd1) >= 4'(LOCK_FRAMES)) begin
            state_d = ST_LOCKED;
            clean_d = 4'd0;
          end else begin
            clean_d = clean_q + 4'd1;
          end
        end else begin
          clean_d = clean_q;
        end
      end
      ST_LOCKED: begin
        if (err_s) begin
          state_d = ST_ALIGN;
          clean_d = 4'd0;
        end else begin
          clean_d = 4'd0;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        clean_d = 4'd0;
      end
    endcase
    locked_d = (state_d == ST_LOCKED);

    pix_vld_d = (state_q == ST_LOCKED) && !err_s &&
                (x_eff_s >= X_LO) && (x_eff_s < X_HI) &&
                (y_eff_s >= Y_LO) && (y_eff_s < Y_HI);
    if (pix_vld_d) begin
      pix_x_d   = XW'(x_eff_s - X_LO);
      pix_y_d   = YW'(y_eff_s - Y_LO);
      pix_rgb_d = {i_r, i_g, i_b};
    end else begin
      pix_x_d   = pix_x_q;
      pix_y_d   = pix_y_q;
      pix_rgb_d = pix_rgb_q;
    end
    fstart_d = pix_vld_d && (x_eff_s == X_LO) && (y_eff_s == Y_LO);
    fdone_d  = pix_vld_d && (x_eff_s == X_END) && (y_eff_s == Y_END);
    fcnt_d   = fdone_d ? fcnt_q + FCNT_W'(1) : fcnt_q;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= ST_UNLOCKED;
      clean_q     <= 4'd0;
      frame_err_q <= 1'b0;
      s_hsd_q     <= 1'b1;
      s_vsd_q     <= 1'b1;
      x_cnt_q     <= '0;
      line_cnt_q  <= '0;
      pix_vld_q   <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_rgb_q   <= '0;
      fstart_q    <= 1'b0;
      fdone_q     <= 1'b0;
      fcnt_q      <= '0;
      locked_q    <= 1'b0;
      h_err_q     <= 1'b0;
      v_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clean_q     <= clean_d;
      frame_err_q <= frame_err_d;
      s_hsd_q     <= i_hsd;
      s_vsd_q     <= i_vsd;
      x_cnt_q     <= x_cnt_d;
      line_cnt_q  <= line_cnt_d;
      pix_vld_q   <= pix_vld_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_rgb_q   <= pix_rgb_d;
      fstart_q    <= fstart_d;
      fdone_q     <= fdone_d;
      fcnt_q      <= fcnt_d;
      locked_q    <= locked_d;
      h_err_q     <= h_err_s;
      v_err_q     <= v_err_s;
    end
  end

  assign o_pix_vld     = pix_vld_q;
  assign o_pix_x       = pix_x_q;
  assign o_pix_y       = pix_y_q;
  assign o_pix_rgb     = pix_rgb_q;
  assign o_frame_start = fstart_q;
  assign o_frame_done  = fdone_q;
  assign o_frame_cnt   = fcnt_q;
  assign o_locked      = locked_q;
  assign o_h_err       = h_err_q;
  assign o_v_err       = v_err_q;

`ifdef LCD_FRAME_MONITOR_CRC_EN
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

  // One MSB-first CRC-32 step over a 24-bit pixel word.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [23:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  logic [31:0] crc_run_q, crc_run_d, crc_out_q, crc_out_d, crc_next_s;

  // CRC works on the registered pixel, so the result lands one cycle after frame_done.
  always_comb begin
    crc_next_s = crc32_step(fstart_q ? 32'hFFFFFFFF : crc_run_q, 24'(pix_rgb_q));
    crc_run_d  = crc_run_q;
    crc_out_d  = crc_out_q;
    if (pix_vld_q) begin
      crc_run_d = crc_next_s;
      if (fdone_q) crc_out_d = ~crc_next_s;
      else         crc_out_d = crc_out_q;
    end else begin
      crc_run_d = crc_run_q;
    end
  end

  // CRC registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      crc_run_q <= 32'hFFFFFFFF;
      crc_out_q <= 32'h00000000;
    end else begin
      crc_run_q <= crc_run_d;
      crc_out_q <= crc_out_d;
    end
  end

  assign o_frame_crc = crc_out_q;
`endif

endmodule

// File: tb/tb_lcd_frame_monitor.sv
// Scoreboard bench for lcd_frame_monitor on a reduced 16x10 timing. The driver
// generates 21 frames: normal frames, a shortened line, a short frame, a
// mid-frame reset and frame-counter wrap. For every pixel it expects to be
// valid it queues the expected output. The monitor dequeues and compares each
// time o_pix_vld is asserted.
module tb_lcd_frame_monitor;
  localparam int HT = 16, VT = 10, HS = 3, HA = 8, VS = 2, VA = 5;
  localparam int CW = 8, FW = 2, LF = 2, NF = 21;

  logic          clk = 1'b0;
  logic          i_rstn, i_hsd, i_vsd;
  logic [CW-1:0] i_r, i_g, i_b;
  logic          o_pix_vld, o_frame_start, o_frame_done, o_locked, o_h_err, o_v_err;
  logic [2:0]    o_pix_x, o_pix_y;
  logic [23:0]   o_pix_rgb;
  logic [FW-1:0] o_frame_cnt;
`ifdef LCD_FRAME_MONITOR_CRC_EN
  logic [31:0]   o_frame_crc;
`endif

  always #5 clk = ~clk;

  lcd_frame_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HS), .H_ACT(HA),
    .V_ACT_START(VS), .V_ACT(VA), .COLOR_W(CW), .FCNT_W(FW), .LOCK_FRAMES(LF)
  ) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_hsd(i_hsd), .i_vsd(i_vsd),
    .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_pix_vld(o_pix_vld), .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .o_pix_rgb(o_pix_rgb),
    .o_frame_start(o_frame_start), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
    .o_locked(o_locked), .o_h_err(o_h_err),
`ifdef LCD_FRAME_MONITOR_CRC_EN
    .o_v_err(o_v_err), .o_frame_crc(o_frame_crc)
`else
    .o_v_err(o_v_err)
`endif
  );

  typedef struct packed {
    logic [2:0]  x;
    logic [2:0]  y;
    logic [23:0] rgb;
    logic        fs;
    logic        fd;
    logic [1:0]  cnt;
    logic [31:0] crc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0;
  int          h_err_seen = 0, v_err_seen = 0;
  logic        mon_en = 1'b0;
  logic [1:0]  exp_cnt = 2'd0;
  logic [31:0] model_crc = 32'hFFFFFFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference CRC-32, MSB-first, processed byte by byte.
  function automatic logic [31:0] crc_model(input logic [31:0] crc, input logic [23:0] rgb);
    logic [31:0] c;
    logic [7:0]  byt;
    c = crc;
    for (int k = 2; k >= 0; k--) begin
      byt = rgb[k*8 +: 8];
      for (int b = 7; b >= 0; b--) begin
        c = (c[31] ^ byt[b]) ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
    end
    return c;
  endfunction

  function automatic bit is_locked(input int f);
    return (f == 2) || (f == 3) || (f == 7) || (f == 8) || (f == 11) || (f == 12) || (f >= 16);
  endfunction

  task automatic push(input int px, input int py, input logic [23:0] rgb);
    exp_t e;
    e.x   = 3'(px);
    e.y   = 3'(py);
    e.rgb = rgb;
    e.fs  = (px == 0) && (py == 0);
    e.fd  = (px == HA - 1) && (py == VA - 1);
    if (e.fs) model_crc = 32'hFFFFFFFF;
    model_crc = crc_model(model_crc, rgb);
    if (e.fd) exp_cnt = exp_cnt + 2'd1;
    e.cnt = exp_cnt;
    e.crc = ~model_crc;
    q.push_back(e);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_pix_vld"}, 64'(o_pix_vld), 64'd0);
    chk({tag, "_pix_x"}, 64'(o_pix_x), 64'd0);
    chk({tag, "_pix_y"}, 64'(o_pix_y), 64'd0);
    chk({tag, "_pix_rgb"}, 64'(o_pix_rgb), 64'd0);
    chk({tag, "_frame_start"}, 64'(o_frame_start), 64'd0);
    chk({tag, "_frame_done"}, 64'(o_frame_done), 64'd0);
    chk({tag, "_frame_cnt"}, 64'(o_frame_cnt), 64'd0);
    chk({tag, "_locked"}, 64'(o_locked), 64'd0);
    chk({tag, "_h_err"}, 64'(o_h_err), 64'd0);
    chk({tag, "_v_err"}, 64'(o_v_err), 64'd0);
`ifdef LCD_FRAME_MONITOR_CRC_EN
    chk({tag, "_frame_crc"}, 64'(o_frame_crc), 64'd0);
`endif
  endtask

  // Frame 4 has a 10-cycle line, frame 8 has 9 lines, frame 13 gets reset at line 4, x 7.
  task automatic drive_frame(input int f);
    int nlines;
    bit lk, vfr, stop, zchk;
    nlines = (f == 8) ? VT - 1 : VT;
    lk     = is_locked(f);
    vfr    = lk || (f == 4) || (f == 13);
    stop   = 1'b0;
    zchk   = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (f == 4 && l == 4) ? 10 : HT;
      for (int x = 0; x < len; x++) begin
        @(posedge clk);
        #1;
        if (zchk) begin
          zero_check("after_rst");
          zchk = 1'b0;
        end
        if (l == 8 && x == 0) chk($sformatf("locked_f%0d", f), 64'(o_locked), 64'(lk));
        if (f == 4 && l == 5) stop = 1'b1;
        i_hsd  = (x >= 2);
        i_vsd  = (l >= 2);
        i_r    = 8'(32'h10 + x);
        i_g    = 8'(32'h20 + l);
        i_b    = 8'(32'h30 + f);
        i_rstn = 1'b1;
        if (f == 13 && l == 4 && x == 7) begin
          i_rstn  = 1'b0;
          stop    = 1'b1;
          zchk    = 1'b1;
          exp_cnt = 2'd0;
        end
        if (vfr && !stop && x >= HS && x < HS + HA && l >= VS && l < VS + VA)
          push(x - HS, l - VS, {i_r, i_g, i_b});
      end
    end
  endtask

  // Monitor: counts error pulses and checks every valid pixel against the queue.
  logic        crc_pend = 1'b0;
  logic [31:0] crc_req;
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (o_h_err) h_err_seen++;
      if (o_v_err) v_err_seen++;
`ifdef LCD_FRAME_MONITOR_CRC_EN
      if (crc_pend) chk("frame_crc", 64'(o_frame_crc), 64'(crc_req));
`endif
      crc_pend = 1'b0;
      if (o_pix_vld) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pix_vld actual x=%0d y=%0d required no valid pixel", o_pix_x, o_pix_y);
        end else begin
          e = q.pop_front();
          chk("pix_x", 64'(o_pix_x), 64'(e.x));
          chk("pix_y", 64'(o_pix_y), 64'(e.y));
          chk("pix_rgb", 64'(o_pix_rgb), 64'(e.rgb));
          chk("frame_start", 64'(o_frame_start), 64'(e.fs));
          chk("frame_done", 64'(o_frame_done), 64'(e.fd));
          chk("frame_cnt", 64'(o_frame_cnt), 64'(e.cnt));
          if (e.fd) begin
            crc_pend = 1'b1;
            crc_req  = e.crc;
          end
        end
      end
    end
  end

  initial begin
    i_rstn = 1'b0;
    i_hsd  = 1'b1;
    i_vsd  = 1'b1;
    i_r    = 8'h00;
    i_g    = 8'h00;
    i_b    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    zero_check("reset");
    mon_en = 1'b1;
    for (int f = 0; f < NF; f++) drive_frame(f);
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("h_err_pulses", 64'(h_err_seen), 64'd1);
    chk("v_err_pulses", 64'(v_err_seen), 64'd1);
    chk("final_frame_cnt", 64'(o_frame_cnt), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
